bus_arb_n: RTL and testbench
============================

# bus_arb_n

Parametrised N-master Wishbone (classic) bus arbiter: the generalised successor to the two-master SERV bus arbiter. It multiplexes N masters (CPU instruction/data ports, DMA, debug) onto one shared slave bus. It offers fixed-priority or round-robin arbitration, holds the grant for the whole `cyc` tenure so block transfers are not interleaved, and has an optional bus-timeout that returns an error to a master whose slave never acknowledges.

## Interface
Parameters:
- `N`, 2: number of masters, 2..8.
- `AW`, 32: address width.
- `DW`, 32: data width, a multiple of 8; `SW = DW/8`.
- `MODE`, 0: 0 = fixed priority (index 0 highest); 1 = round-robin.
- `TIMEOUT`, 0: number of stalled cycles before a bus error; 0 disables the timeout.

Ports (master `i` occupies slice `[i*W +: W]` of each packed vector):
- `wb_clk` in 1: the only clock; all state changes on its rising edge.
- `wb_rst_n` in 1: asynchronous, active-low reset.
- `m_cyc` in N: per-master cycle request.
- `m_stb` in N: per-master strobe.
- `m_we` in N: per-master write enable.
- `m_adr` in N*AW: per-master address.
- `m_dat` in N*DW: per-master write data.
- `m_sel` in N*SW: per-master byte selects.
- `m_ack` out N: per-master acknowledge.
- `m_err` out N: per-master timeout error pulse.
- `m_rdt` out DW: read data, shared by all masters; valid only with that master's `m_ack`.
- `s_cyc`, `s_stb`, `s_we` out 1: slave-side controls.
- `s_adr` out AW, `s_dat` out DW, `s_sel` out SW: slave-side address, write data and byte selects.
- `s_ack` in 1, `s_rdt` in DW: slave acknowledge and read data.
- `grant` out N: one-hot registered owner; all zero when the bus is idle.

## Operation
- States: IDLE, BUSY, DRAIN. Reset puts the arbiter in IDLE.
- Reset values: `grant = 0`, `last = N-1`, timeout counter = 0. All `s_*` outputs and `m_ack`/`m_err` are 0 while `grant == 0`.

IDLE
- If any `m_cyc` is high, select a winner, register `grant` to its one-hot index and go to BUSY.
- Fixed priority (MODE 0): the lowest requesting index wins.
- Round-robin (MODE 1): the first requester found searching `last+1, last+2, …` modulo N wins.
- On a grant, `last` is set to the winner's index.

BUSY
- `s_cyc`, `s_stb`, `s_we`, `s_adr`, `s_dat` and `s_sel` are combinational muxes of the granted master's signals.
- `m_ack[g] = s_ack & m_stb[g]`. `m_rdt = s_rdt` passes straight through.
- Ungranted masters see `ack = 0` and `err = 0`; their requests stay pending with no loss.
- The grant holds while `m_cyc[g]` stays high, across any number of strobes.
- When `m_cyc[g]` is sampled low, the arbiter clears `grant` and returns to IDLE.

Timeout (only when `TIMEOUT > 0`)
- The counter increments each BUSY cycle with `s_stb & ~s_ack`. It clears on `s_ack`, on `~s_stb`, and on leaving BUSY.
- When the counter reaches `TIMEOUT`, `m_err[g]` pulses for exactly 1 cycle, `s_cyc` and `s_stb` are forced low from that cycle, and the state goes to DRAIN.
- A slave `s_ack` arriving in that same cycle wins: the master sees `ack`, no `err`, and the arbiter stays in BUSY.

DRAIN
- `grant` is kept (the register is not cleared); `s_*` are held inactive and `m_ack`/`m_err` stay 0.
- Stay in DRAIN until `m_cyc[g]` is sampled low, then go to IDLE with `grant = 0`.

Other rules
- Counter width is `$clog2(TIMEOUT+1)`. It saturates and never wraps.
- An asynchronous reset asserted mid-transfer immediately drops `s_cyc`, `s_stb` and `grant`. No ack or err is generated for the aborted transfer.

## Timing
- Grant latency: `m_cyc` high in IDLE at cycle 0 gives `grant` and `s_cyc` high in cycle 1.
- Ack path: `s_ack → m_ack` is combinational, zero cycles.
- Release: `m_cyc[g]` low at cycle k gives `grant = 0` in cycle k+1. The next grant is issued in cycle k+2, so there is exactly 1 idle cycle between tenures.
- Timeout: with `s_stb` held and no ack from cycle 1, `m_err` is high in cycle `1+TIMEOUT`.
- Simultaneous requests in IDLE are resolved in one cycle; there is never more than one grant bit set.

## Test plan
- Single master, N=4, MODE 0: master 2 does a write then a read (slave acks after 2 wait states, `s_rdt = 0xDEADBEEF`) -> `grant = 0100` from cycle 1; `m_ack[2]` is asserted twice; master 2 sees `m_rdt = 0xDEADBEEF`; `grant = 0` in the cycle after `cyc` drops.
- Fixed priority, N=4: masters 1 and 3 request together continuously -> master 1 always wins and master 3 is never granted while master 1 keeps re-requesting.
- Round-robin, N=4: all four request continuously with 1-beat tenures -> grant sequence 0,1,2,3,0,…, with each grant separated by one idle cycle.
- Locked burst: master 0 holds `cyc` for 4 strobes while master 1 requests -> `grant` stays `01` for all 4 acks, and master 1 is granted 2 cycles after master 0 drops `cyc`.
- Timeout, TIMEOUT=8: slave never acks -> `m_err[g]` pulses in cycle 9 and `s_cyc` is low from cycle 9. DRAIN holds until `m_cyc` falls. A second run that acks in cycle 9 gives ack and no err.
- Async reset: assert `wb_rst_n = 0` mid-burst -> `s_cyc`, `grant`, `m_ack` and `m_err` all go to 0 within the same cycle, and arbitration restarts cleanly after reset is released.

Source files
------------

// File: rtl/bus_arb_n.sv
// bus_arb_n: N-master Wishbone classic arbiter, one shared slave bus.
// Fixed-priority or round-robin grant, held per cyc tenure, optional timeout.
//
// Ports (master i uses slice [i*W +: W] of each packed vector):
//   wb_clk, wb_rst_n           clock, async active-low reset
//   m_cyc/m_stb/m_we  [N]      master controls
//   m_adr/m_dat/m_sel          master address, write data, byte selects
//   m_ack/m_err       [N]      per-master ack and timeout-error pulse
//   m_rdt             [DW]     shared read data (valid with own m_ack)
//   s_cyc/s_stb/s_we           slave controls
//   s_adr/s_dat/s_sel          slave address, write data, byte selects
//   s_ack, s_rdt               slave ack and read data
//   grant             [N]      registered one-hot owner, 0 when idle
module bus_arb_n #(
  parameter int N       = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 0
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  input  logic [N-1:0]          m_cyc,
  input  logic [N-1:0]          m_stb,
  input  logic [N-1:0]          m_we,
  input  logic [N*AW-1:0]       m_adr,
  input  logic [N*DW-1:0]       m_dat,
  input  logic [N*(DW/8)-1:0]   m_sel,
  output logic [N-1:0]          m_ack,
  output logic [N-1:0]          m_err,
  output logic [DW-1:0]         m_rdt,
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [AW-1:0]         s_adr,
  output logic [DW-1:0]         s_dat,
  output logic [(DW/8)-1:0]     s_sel,
  input  logic                  s_ack,
  input  logic [DW-1:0]         s_rdt,
  output logic [N-1:0]          grant
);

  localparam int SW = DW / 8;
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_t;

  state_t          state_q;
  logic [N-1:0]    grant_q;
  logic [LW-1:0]   last_q;
  logic [CW-1:0]   cnt_q;

  logic [LW-1:0]   win_d;
  logic [N-1:0]    win_oh;
  logic            busy;
  logic            cyc_g;
  logic            stb_g;
  logic            expire;
  logic            tmo_err;

  // Winner selection, evaluated every cycle but only used in IDLE.
  always_comb begin
    logic [LW-1:0] j;
    logic          found;
    win_d = '0;
    found = 1'b0;
    j     = '0;
    if (MODE == 1) begin
      for (int k = 1; k <= N; k++) begin
        j = LW'((int'(last_q) + k) % N);
        if (!found && m_cyc[j]) begin
          found = 1'b1;
          win_d = j;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        j = LW'(k);
        if (!found && m_cyc[j]) begin
          found = 1'b1;
          win_d = j;
        end
      end
    end
  end

  assign win_oh = N'(1) << win_d;

  assign busy  = (state_q == BUSY);
  assign cyc_g = |(m_cyc & grant_q);
  assign stb_g = |(m_stb & grant_q);

  // A slave ack in the expiry cycle wins over the error, so the forced
  // drop of s_cyc/s_stb depends on s_ack combinationally.
  assign expire  = (TIMEOUT > 0) && busy && stb_g &&
                   (cnt_q == CW'(TIMEOUT));
  assign tmo_err = expire && !s_ack;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(N - 1);
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (|m_cyc) begin
            grant_q <= win_oh;
            last_q  <= win_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!cyc_g) begin
            state_q <= IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
          end else if (tmo_err) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end else if (s_ack || !stb_g) begin
            cnt_q <= '0;
          end else if (cnt_q != CW'(TIMEOUT)) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DRAIN: begin
          if (!cyc_g) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Slave-side mux; grant_q is one-hot so at most one slice matches.
  always_comb begin
    s_we  = 1'b0;
    s_adr = '0;
    s_dat = '0;
    s_sel = '0;
    if (busy) begin
      for (int i = 0; i < N; i++) begin
        if (grant_q[i]) begin
          s_we  = m_we[i];
          s_adr = m_adr[i*AW +: AW];
          s_dat = m_dat[i*DW +: DW];
          s_sel = m_sel[i*SW +: SW];
        end
      end
    end
  end

  assign s_cyc = busy && cyc_g && !tmo_err;
  assign s_stb = busy && stb_g && !tmo_err;
  assign m_ack = busy ? (grant_q & m_stb & {N{s_ack}}) : '0;
  assign m_err = tmo_err ? grant_q : '0;
  assign m_rdt = s_rdt;
  assign grant = grant_q;

endmodule

// File: tb/tb_bus_arb_n.sv
// tb_bus_arb_n: directed bench for bus_arb_n with a result scoreboard.
// Fixed-priority/timeout instance plus a round-robin instance.
module tb_bus_arb_n;

  logic         clk;
  logic         rst_n;

  logic [3:0]   m_cyc, m_stb, m_we;
  logic [127:0] m_adr, m_dat;
  logic [15:0]  m_sel;
  logic [3:0]   m_ack, m_err, grant;
  logic [31:0]  m_rdt, s_adr, s_dat, s_rdt;
  logic         s_cyc, s_stb, s_we, s_ack;
  logic [3:0]   s_sel;

  logic [3:0]   rr_cyc, rr_stb;
  logic [3:0]   rr_ack, rr_err, rr_grant;
  logic [31:0]  rr_rdt, rr_sadr, rr_sdat;
  logic         rr_scyc, rr_sstb, rr_swe, rr_sack;
  logic [3:0]   rr_ssel;

  int ntests = 0;
  int nfail  = 0;
  logic [31:0] sbq[$];

  bus_arb_n #(.N(4), .AW(32), .DW(32), .MODE(0), .TIMEOUT(8)) u_fp (
    .wb_clk(clk), .wb_rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_adr(m_adr), .m_dat(m_dat), .m_sel(m_sel),
    .m_ack(m_ack), .m_err(m_err), .m_rdt(m_rdt),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_adr(s_adr), .s_dat(s_dat), .s_sel(s_sel),
    .s_ack(s_ack), .s_rdt(s_rdt), .grant(grant)
  );

  bus_arb_n #(.N(4), .AW(32), .DW(32), .MODE(1), .TIMEOUT(0)) u_rr (
    .wb_clk(clk), .wb_rst_n(rst_n),
    .m_cyc(rr_cyc), .m_stb(rr_stb), .m_we(4'b0),
    .m_adr(m_adr), .m_dat(m_dat), .m_sel(m_sel),
    .m_ack(rr_ack), .m_err(rr_err), .m_rdt(rr_rdt),
    .s_cyc(rr_scyc), .s_stb(rr_sstb), .s_we(rr_swe),
    .s_adr(rr_sadr), .s_dat(rr_sdat), .s_sel(rr_ssel),
    .s_ack(rr_sack), .s_rdt(s_rdt), .grant(rr_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] oh(int i);
    return 32'(1) << i;
  endfunction

  initial begin
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    s_ack = 1'b0; s_rdt = '0;
    rr_cyc = '0; rr_stb = '0; rr_sack = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_scyc", 32'(s_cyc), 0);
    chk("rst_ack", 32'(m_ack), 0);
    chk("rst_err", 32'(m_err), 0);
    chk("rst_rr_grant", 32'(rr_grant), 0);
    rst_n = 1'b1;
    tick();

    // single master 2: write then read, 2 wait states each
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1;
    m_adr[64 +: 32] = 32'h100;
    m_dat[64 +: 32] = 32'h1234_5678;
    m_sel[8 +: 4]   = 4'hF;
    sbq.push_back(oh(2));
    tick();
    chk("sm_grant", 32'(grant), sbq.pop_front());
    chk("sm_scyc", 32'(s_cyc), 1);
    chk("sm_swe", 32'(s_we), 1);
    chk("sm_sadr", s_adr, 32'h100);
    chk("sm_sdat", s_dat, 32'h1234_5678);
    chk("sm_ssel", 32'(s_sel), 32'hF);
    chk("sm_wait", 32'(m_ack), 0);
    tick();
    tick();
    s_ack = 1'b1;
    #1;
    chk("sm_wr_ack", 32'(m_ack), oh(2));
    tick();
    s_ack = 1'b0;
    m_we[2] = 1'b0;
    m_adr[64 +: 32] = 32'h104;
    sbq.push_back(32'hDEAD_BEEF);
    #1;
    chk("sm_rd_wait", 32'(m_ack), 0);
    chk("sm_rd_we", 32'(s_we), 0);
    tick();
    tick();
    s_ack = 1'b1;
    s_rdt = 32'hDEAD_BEEF;
    #1;
    chk("sm_rd_ack", 32'(m_ack), oh(2));
    chk("sm_rdt", m_rdt, sbq.pop_front());
    tick();
    s_ack = 1'b0;
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    #1;
    chk("sm_hold", 32'(grant), oh(2));
    tick();
    chk("sm_release", 32'(grant), 0);
    chk("sm_rel_scyc", 32'(s_cyc), 0);

    // fixed priority: 1 and 3 contend, 1 keeps re-requesting
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      sbq.push_back(oh(1));
      tick();
      s_ack = 1'b1;
      #1;
      chk("fp_grant", 32'(grant), sbq.pop_front());
      chk("fp_ack", 32'(m_ack), oh(1));
      tick();
      s_ack = 1'b0;
      m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
      #1;
      chk("fp_hold", 32'(grant), oh(1));
      tick();
      chk("fp_idle", 32'(grant), 0);
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    end
    tick();
    chk("fp_last", 32'(grant), oh(1));
    m_cyc = '0; m_stb = '0;
    tick();
    tick();
    chk("fp_done", 32'(grant), 0);

    // locked burst: master 0 four strobes, master 1 waiting
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    sbq.push_back(oh(0));
    tick();
    chk("lb_grant", 32'(grant), sbq.pop_front());
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b1;
      #1;
      chk("lb_ack", 32'(m_ack), oh(0));
      chk("lb_lock", 32'(grant), oh(0));
      tick();
    end
    s_ack = 1'b0;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
    sbq.push_back(oh(1));
    tick();
    chk("lb_gap", 32'(grant), 0);
    tick();
    chk("lb_next", 32'(grant), sbq.pop_front());
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick();
    tick();

    // timeout, slave never acks
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    sbq.push_back(oh(2));
    tick();
    chk("to_grant", 32'(grant), sbq.pop_front());
    repeat (7) tick();
    chk("to_c8_err", 32'(m_err), 0);
    chk("to_c8_scyc", 32'(s_cyc), 1);
    tick();
    chk("to_c9_err", 32'(m_err), oh(2));
    chk("to_c9_scyc", 32'(s_cyc), 0);
    chk("to_c9_sstb", 32'(s_stb), 0);
    tick();
    chk("to_c10_err", 32'(m_err), 0);
    chk("to_c10_scyc", 32'(s_cyc), 0);
    chk("to_drain", 32'(grant), oh(2));
    tick();
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    tick();
    chk("to_release", 32'(grant), 0);

    // timeout race: ack arrives in the expiry cycle
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    tick();
    repeat (7) tick();
    tick();
    s_ack = 1'b1;
    #1;
    chk("tr_ack", 32'(m_ack), oh(2));
    chk("tr_err", 32'(m_err), 0);
    tick();
    s_ack = 1'b0;
    #1;
    chk("tr_busy", 32'(s_cyc), 1);
    chk("tr_grant", 32'(grant), oh(2));
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    tick();
    tick();

    // async reset mid-burst
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    s_ack = 1'b1;
    #1;
    chk("ar_ack", 32'(m_ack), oh(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_scyc", 32'(s_cyc), 0);
    chk("ar_sstb", 32'(s_stb), 0);
    chk("ar_grant", 32'(grant), 0);
    chk("ar_mack", 32'(m_ack), 0);
    chk("ar_merr", 32'(m_err), 0);
    s_ack = 1'b0;
    m_cyc = '0; m_stb = '0;
    tick();
    rst_n = 1'b1;
    tick();
    m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
    sbq.push_back(oh(3));
    tick();
    chk("ar_restart", 32'(grant), sbq.pop_front());
    chk("ar_rs_scyc", 32'(s_cyc), 1);
    m_cyc = '0; m_stb = '0;
    tick();
    tick();

    // round-robin: all four request, 1-beat tenures
    rr_cyc = 4'hF; rr_stb = 4'hF; rr_sack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sbq.push_back(oh(k % 4));
      tick();
      chk("rr_grant", 32'(rr_grant), sbq.pop_front());
      chk("rr_ack", 32'(rr_ack), oh(k % 4));
      tick();
      rr_cyc[k % 4] = 1'b0; rr_stb[k % 4] = 1'b0;
      #1;
      chk("rr_hold_ack", 32'(rr_ack), 0);
      tick();
      chk("rr_idle", 32'(rr_grant), 0);
      rr_cyc[k % 4] = 1'b1; rr_stb[k % 4] = 1'b1;
    end
    rr_cyc = '0; rr_stb = '0; rr_sack = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
